// File: rtl/stream_mux_pkg.sv
// rtl/stream_mux_pkg.sv - shared parameters and index helpers for stream_mux_n
//
// Contents:
//   DEFAULT_WIDTH, DEFAULT_CHANNELS : default channel width and channel count
//   sel_width(n)                    : ceil(log2(max(n, 2))), width of a channel index
//   next_index(idx, n)              : idx + 1 modulo n
package stream_mux_pkg;

    localparam int DEFAULT_WIDTH    = 32;
    localparam int DEFAULT_CHANNELS = 8;

    function automatic int sel_width(input int n);
        return $clog2((n < 2) ? 2 : n);
    endfunction

    function automatic int next_index(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/stream_mux_n_rr_pick.sv
// rtl/stream_mux_n_rr_pick.sv - rotating-priority encoder for round-robin channel choice
//
// Purely combinational.
// Ports:
//   valid_i      : per-channel valid vector
//   last_grant_i : channel granted most recently; scanning starts one past it
//   cand_o       : first valid channel found, wrapping at CHANNELS
//   any_valid_o  : at least one channel is valid (cand_o meaningful)
module rr_pick
    import stream_mux_pkg::*;
#(
    parameter int CHANNELS = DEFAULT_CHANNELS,
    parameter int SEL_W    = sel_width(CHANNELS)
) (
    input  logic [CHANNELS-1:0] valid_i,
    input  logic [SEL_W-1:0]    last_grant_i,
    output logic [SEL_W-1:0]    cand_o,
    output logic                any_valid_o
);

    logic [SEL_W-1:0] probe;

    // Walk CHANNELS positions starting after last_grant; the last one probed
    // is last_grant itself, so a lone valid channel is re-granted.
    always_comb begin
        cand_o      = '0;
        any_valid_o = 1'b0;
        probe       = last_grant_i;
        for (int off = 0; off < CHANNELS; off++) begin
            probe = SEL_W'(next_index(int'(probe), CHANNELS));
            if (!any_valid_o && valid_i[probe]) begin
                any_valid_o = 1'b1;
                cand_o      = probe;
            end
        end
    end

endmodule

// File: rtl/stream_mux_n.sv
// rtl/stream_mux_n.sv - N:1 stream multiplexer with one-deep registered output
//
// Optional feature macro: STREAM_MUX_RR_EN (adds rr_mode port and round-robin pick).
// Ports:
//   clock, reset : single clock, synchronous active-high reset
//   in_data      : CHANNELS*WIDTH, channel k at [k*WIDTH +: WIDTH]
//   in_valid     : per-channel valid
//   in_ready     : per-channel ready, at most one bit set
//   select       : explicit channel index (fixed mode)
//   rr_mode      : 1 = round-robin pick (only with STREAM_MUX_RR_EN)
//   out_data     : registered data
//   out_valid    : registered valid
//   out_chan     : channel that supplied out_data
//   out_ready    : consumer ready
module stream_mux_n
    import stream_mux_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int CHANNELS = DEFAULT_CHANNELS
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [CHANNELS*WIDTH-1:0]        in_data,
    input  logic [CHANNELS-1:0]              in_valid,
    output logic [CHANNELS-1:0]              in_ready,
    input  logic [sel_width(CHANNELS)-1:0]   select,
`ifdef STREAM_MUX_RR_EN
    input  logic                             rr_mode,
`endif
    output logic [WIDTH-1:0]                 out_data,
    output logic                             out_valid,
    output logic [sel_width(CHANNELS)-1:0]   out_chan,
    input  logic                             out_ready
);

    localparam int SEL_W = sel_width(CHANNELS);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] out_chan_q, out_chan_d;

    logic [SEL_W-1:0] cand;
    logic             cand_ok;
    logic             sel_ok;
    logic             load;
    logic             capture;

    // A select index beyond the last channel names no channel at all; when
    // CHANNELS fills the index space every select value is legal.
    generate
        if ((1 << SEL_W) == CHANNELS) begin : g_sel_full
            assign sel_ok = 1'b1;
        end else begin : g_sel_range
            assign sel_ok = (int'(select) < CHANNELS);
        end
    endgenerate

`ifdef STREAM_MUX_RR_EN
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

    logic [SEL_W-1:0] last_grant_q, last_grant_d;
    logic [SEL_W-1:0] rr_cand;
    logic             rr_any;

    rr_pick #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_rr_pick (
        .valid_i      (in_valid),
        .last_grant_i (last_grant_q),
        .cand_o       (rr_cand),
        .any_valid_o  (rr_any)
    );

    assign cand    = rr_mode ? rr_cand : select;
    assign cand_ok = rr_mode ? rr_any  : sel_ok;
`else
    assign cand    = select;
    assign cand_ok = sel_ok;
`endif

    assign load    = !out_valid_q || out_ready;
    assign capture = load && cand_ok && in_valid[cand] && !reset;

    // Fixed mode offers ready on the selected channel even if it is idle.
    always_comb begin
        in_ready = '0;
        if (cand_ok && !reset) begin
            in_ready[cand] = load;
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_chan_d  = out_chan_q;
        if (capture) begin
            out_data_d  = in_data[int'(cand)*WIDTH +: WIDTH];
            out_chan_d  = cand;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

`ifdef STREAM_MUX_RR_EN
    always_comb begin
        last_grant_d = last_grant_q;
        if (capture && rr_mode) begin
            last_grant_d = cand;
        end
    end

    // Reset value of last channel gives channel 0 first priority.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant_q <= LAST_CH;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_chan_q  <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_chan_q  <= out_chan_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_stream_mux_n.sv
// tb/tb_stream_mux_n.sv - scoreboard testbench for stream_mux_n (8- and 5-channel instances)
module tb_stream_mux_n;

    typedef struct {
        int          chan;
        logic [31:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // 8-channel instance
    logic [31:0]  d8 [8];
    logic [255:0] in_data8;
    logic [7:0]   in_valid8;
    logic [7:0]   in_ready8;
    logic [2:0]   select8;
    logic         rr_mode8;
    logic [31:0]  out_data8;
    logic         out_valid8;
    logic [2:0]   out_chan8;
    logic         out_ready8;

    // 5-channel instance
    logic [31:0]  d5 [5];
    logic [159:0] in_data5;
    logic [4:0]   in_valid5;
    logic [4:0]   in_ready5;
    logic [2:0]   select5;
    logic         rr_mode5;
    logic [31:0]  out_data5;
    logic         out_valid5;
    logic [2:0]   out_chan5;
    logic         out_ready5;

    always_comb begin
        for (int k = 0; k < 8; k++) in_data8[k*32 +: 32] = d8[k];
        for (int k = 0; k < 5; k++) in_data5[k*32 +: 32] = d5[k];
    end

    stream_mux_n #(.WIDTH(32), .CHANNELS(8)) dut8 (
        .clock     (clk),
        .reset     (reset),
        .in_data   (in_data8),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .select    (select8),
`ifdef STREAM_MUX_RR_EN
        .rr_mode   (rr_mode8),
`endif
        .out_data  (out_data8),
        .out_valid (out_valid8),
        .out_chan  (out_chan8),
        .out_ready (out_ready8)
    );

    stream_mux_n #(.WIDTH(32), .CHANNELS(5)) dut5 (
        .clock     (clk),
        .reset     (reset),
        .in_data   (in_data5),
        .in_valid  (in_valid5),
        .in_ready  (in_ready5),
        .select    (select5),
`ifdef STREAM_MUX_RR_EN
        .rr_mode   (rr_mode5),
`endif
        .out_data  (out_data5),
        .out_valid (out_valid5),
        .out_chan  (out_chan5),
        .out_ready (out_ready5)
    );

    int n_checks = 0;
    int n_fail   = 0;
    beat_t q8[$];
    beat_t q5[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push8(input int chan, input logic [31:0] data);
        beat_t b;
        b.chan = chan;
        b.data = data;
        q8.push_back(b);
    endtask

    task automatic push5(input int chan, input logic [31:0] data);
        beat_t b;
        b.chan = chan;
        b.data = data;
        q5.push_back(b);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // Monitors: a beat leaves when out_valid && out_ready at the coming edge.
    always @(negedge clk) begin
        if (!reset && out_valid8 && out_ready8) begin
            if (q8.size() == 0) begin
                check("mon8_unexpected_beat", {29'd0, out_chan8}, 64'hFFFF);
            end else begin
                beat_t b;
                b = q8.pop_front();
                check("mon8_chan", {61'd0, out_chan8}, 64'(b.chan));
                check("mon8_data", {32'd0, out_data8}, {32'd0, b.data});
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && out_valid5 && out_ready5) begin
            if (q5.size() == 0) begin
                check("mon5_unexpected_beat", {61'd0, out_chan5}, 64'hFFFF);
            end else begin
                beat_t b;
                b = q5.pop_front();
                check("mon5_chan", {61'd0, out_chan5}, 64'(b.chan));
                check("mon5_data", {32'd0, out_data5}, {32'd0, b.data});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 8; k++) d8[k] = '0;
        for (int k = 0; k < 5; k++) d5[k] = '0;
        reset      = 1'b1;
        in_valid8  = 8'h08;
        select8    = 3'd3;
        rr_mode8   = 1'b0;
        out_ready8 = 1'b1;
        in_valid5  = '0;
        select5    = 3'd0;
        rr_mode5   = 1'b0;
        out_ready5 = 1'b1;

        // Reset state; in_ready held low during reset.
        step();
        at_neg();
        check("reset_out_valid", {63'd0, out_valid8}, 64'd0);
        check("reset_out_data", {32'd0, out_data8}, 64'd0);
        check("reset_out_chan", {61'd0, out_chan8}, 64'd0);
        check("reset_in_ready", {56'd0, in_ready8}, 64'd0);
        step();
        reset = 1'b0;

        // Fixed mode, select 3.
        d8[3] = 32'hDEADBEEF;
        push8(3, 32'hDEADBEEF);
        at_neg();
        check("fixed_in_ready", {56'd0, in_ready8}, 64'h08);
        step();
        in_valid8 = 8'h00;
        at_neg();
        check("latency_out_valid", {63'd0, out_valid8}, 64'd1);
        check("latency_out_data", {32'd0, out_data8}, 64'hDEADBEEF);
        check("latency_out_chan", {61'd0, out_chan8}, 64'd3);
        step();

        // Stall: beat from ch3 held while select and data change.
        d8[3]      = 32'h11111111;
        in_valid8  = 8'h08;
        out_ready8 = 1'b0;
        push8(3, 32'h11111111);
        at_neg();
        check("stall_setup_in_ready", {56'd0, in_ready8}, 64'h08);
        step();
        select8   = 3'd5;
        in_valid8 = 8'h28;
        d8[5]     = 32'h55555555;
        for (int i = 0; i < 4; i++) begin
            d8[3] = 32'h22222222 + 32'(i);
            at_neg();
            check("stall_out_valid", {63'd0, out_valid8}, 64'd1);
            check("stall_out_data", {32'd0, out_data8}, 64'h11111111);
            check("stall_out_chan", {61'd0, out_chan8}, 64'd3);
            check("stall_in_ready", {56'd0, in_ready8}, 64'd0);
            step();
        end
        out_ready8 = 1'b1;
        push8(5, 32'h55555555);
        at_neg();
        check("release_in_ready", {56'd0, in_ready8}, 64'h20);
        step();
        in_valid8 = 8'h00;
        at_neg();
        check("no_bubble_out_valid", {63'd0, out_valid8}, 64'd1);
        check("no_bubble_out_chan", {61'd0, out_chan8}, 64'd5);
        step();

        // Back-to-back throughput on ch2.
        select8   = 3'd2;
        in_valid8 = 8'h04;
        for (int i = 0; i < 4; i++) begin
            d8[2] = 32'h30000000 + 32'(i);
            push8(2, d8[2]);
            at_neg();
            step();
        end
        in_valid8 = 8'h00;
        at_neg();
        step();

        // 5-channel instance: out-of-range select gets no ready and no capture.
        select5   = 3'd6;
        in_valid5 = 5'h1F;
        for (int k = 0; k < 5; k++) d5[k] = 32'h50000000 + 32'(k);
        at_neg();
        check("sel6_in_ready", {59'd0, in_ready5}, 64'd0);
        step();
        at_neg();
        check("sel6_no_capture", {63'd0, out_valid5}, 64'd0);
        in_valid5 = 5'h00;
        select5   = 3'd0;
        step();

        // Reset while a beat is stalled.
        select8    = 3'd1;
        in_valid8  = 8'h02;
        d8[1]      = 32'hCAFEF00D;
        out_ready8 = 1'b0;
        step();
        in_valid8 = 8'h00;
        at_neg();
        check("pre_reset_held", {63'd0, out_valid8}, 64'd1);
        step();
        reset      = 1'b1;
        out_ready8 = 1'b1;
        at_neg();
        check("in_reset_in_ready", {56'd0, in_ready8}, 64'd0);
        step();
        reset = 1'b0;
        at_neg();
        check("post_reset_out_valid", {63'd0, out_valid8}, 64'd0);
        check("post_reset_out_data", {32'd0, out_data8}, 64'd0);
        check("post_reset_out_chan", {61'd0, out_chan8}, 64'd0);
        step();

`ifdef STREAM_MUX_RR_EN
        // Round robin, all valid: 0..7 then wrap to 0.
        for (int k = 0; k < 8; k++) d8[k] = 32'hA0000000 + 32'(k);
        rr_mode8  = 1'b1;
        in_valid8 = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            push8(i % 8, 32'hA0000000 + 32'(i % 8));
            at_neg();
            step();
        end
        // Channels 1 and 7 valid; last grant was 0.
        in_valid8 = 8'h82;
        push8(1, 32'hA0000001);
        push8(7, 32'hA0000007);
        push8(1, 32'hA0000001);
        push8(7, 32'hA0000007);
        for (int i = 0; i < 4; i++) begin
            at_neg();
            step();
        end
        // A fixed-mode capture leaves the pointer at 7, so next RR grant is 0.
        rr_mode8  = 1'b0;
        select8   = 3'd3;
        in_valid8 = 8'h08;
        push8(3, 32'hA0000003);
        at_neg();
        step();
        rr_mode8  = 1'b1;
        in_valid8 = 8'hFF;
        push8(0, 32'hA0000000);
        at_neg();
        step();
        in_valid8 = 8'h00;
        rr_mode8  = 1'b0;

        // 5 channels, only 0 and 4 valid: 0,4,0,4 from reset.
        rr_mode5  = 1'b1;
        in_valid5 = 5'h11;
        push5(0, 32'h50000000);
        push5(4, 32'h50000004);
        push5(0, 32'h50000000);
        push5(4, 32'h50000004);
        for (int i = 0; i < 4; i++) begin
            at_neg();
            step();
        end
        in_valid5 = 5'h00;
        rr_mode5  = 1'b0;
`endif

        for (int i = 0; i < 4; i++) step();
        check("q8_drained", 64'(q8.size()), 64'd0);
        check("q5_drained", 64'(q5.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_mux_n.md
# stream_mux_n

Parametrised N:1 streaming multiplexer with a one-deep registered output and valid/ready handshake on every channel. It is the pipelined, handshaked successor to the combinational 2/4/8-way 32-bit muxes. It sits between producers (ALU result, load unit, forwarding sources, debug port) and a single consumer such as a writeback or trace port. Channel choice is an explicit select, or optionally a fair round-robin pick among valid channels.

## Interface
- WIDTH, 32, data bits per channel (≥1)
- CHANNELS, 8, number of input channels (≥2; need not be a power of two)
- SEL_W, $clog2(CHANNELS), select/channel-index width (derived; not overridden)
- clock  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in_data  input  CHANNELS*WIDTH  channel k at bits [k*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  per-channel valid
- in_ready  output  CHANNELS  per-channel ready; at most one bit set per cycle
- select  input  SEL_W  explicit channel index (fixed mode)
- rr_mode  input  1  1 = round-robin pick, 0 = explicit select (present only with STREAM_MUX_RR_EN)
- out_data  output  WIDTH  registered data
- out_valid  output  1  registered valid
- out_chan  output  SEL_W  index of the channel that supplied out_data
- out_ready  input  1  consumer ready

## Operation
- Output register state: out_valid, out_data, out_chan; rr pointer last_grant (SEL_W bits).
- load = !out_valid || out_ready; evaluated combinationally every cycle.
- Fixed mode: candidate = select. If select ≥ CHANNELS, there is no candidate and all in_ready = 0.
- RR mode: candidate = first k with in_valid[k], scanning last_grant+1, last_grant+2, … modulo CHANNELS. Wrap is at CHANNELS, not 2^SEL_W. select is ignored.
- in_ready[candidate] = load. All other in_ready bits = 0. In fixed mode in_ready[select] is asserted even when in_valid[select] = 0.
- Capture (transfer) = load && in_valid[candidate]:
  - out_data ← channel data; out_chan ← candidate; out_valid ← 1.
  - In RR mode, last_grant ← candidate.
- No capture and out_ready = 1: out_valid ← 0. out_data and out_chan hold their old values.
- Stall (out_valid && !out_ready): out_data, out_valid and out_chan are held. Changes on select, rr_mode or in_valid have no effect on the held beat.
- last_grant updates only on an RR capture. A fixed-mode capture does not change it.
- Switching rr_mode takes effect for the next capture decision. A beat already held is never modified.

## Timing
- Reset values: out_valid = 0, out_data = 0, out_chan = 0, last_grant = CHANNELS-1 (so channel 0 has first priority).
- Reset mid-operation discards any held beat. in_ready is 0 during the reset cycle.
- Latency: capture at edge t → out_valid = 1 in the cycle after t.
- Throughput: one beat per cycle while out_ready stays high.
- Combinational paths: out_ready → in_ready, and in_valid/select → in_ready. No path from in_* to out_*.
- Simultaneous out_ready = 1 and a new capture: the old beat leaves and the new beat loads in the same edge, with no bubble.

## Configuration
- STREAM_MUX_RR_EN defined:
  - rr_mode port exists.
  - last_grant register and round-robin pick logic are built.
- STREAM_MUX_RR_EN undefined:
  - rr_mode port is absent and there is no last_grant register.
  - The block always runs in fixed mode, with behaviour identical to rr_mode = 0.

## Structure
- Package stream_mux_pkg holds:
  - DEFAULT_WIDTH = 32, DEFAULT_CHANNELS = 8.
  - A function sel_width(n) returning the ceiling of log2 of max(n, 2).
  - A function next_index(idx, n) implementing modulo-n increment.
- Sub-module rr_pick: a rotating-priority encoder.
  - Inputs: valid vector and last_grant.
  - Outputs: candidate index and any_valid.
  - Purely combinational. Instantiated only under STREAM_MUX_RR_EN.

## Test plan
- Reset, then fixed mode with select = 3, in_valid = 8'h08, in_data ch3 = 32'hDEADBEEF, out_ready = 1 → in_ready = 8'h08; next cycle out_valid = 1, out_data = 32'hDEADBEEF, out_chan = 3.
- Stall: hold out_ready = 0 for 4 cycles while changing select to 5 and ch3 data → out_data, out_chan and out_valid stay constant; in_ready = 0. Release out_ready → the ch5 beat loads with no bubble.
- RR with in_valid = 8'hFF continuously and out_ready = 1 → out_chan sequence 0,1,2,…,7,0 after reset. With in_valid = 8'h82 → out_chan alternates 1,7,1,7.
- CHANNELS = 5, RR with only channels 4 and 0 valid → grants wrap 4→0→4, never indexing 5–7. Fixed mode with select = 6 → in_ready = 0 and no capture.
- Reset asserted while out_valid = 1 and out_ready = 0 → next cycle out_valid = 0, out_data = 0, and the first RR grant after reset goes to channel 0.
- Build without STREAM_MUX_RR_EN → the fixed-mode scenarios pass unchanged and the elaborated design has no rr_mode port.
